// File: rtl/inst_mem_stream.sv
// Streamed-load instruction memory for the MIPS fetch stage: combinational fetch,
// word-by-word valid/ready loader with a programmable, clamped word count.
module inst_mem_stream #(
  parameter int unsigned         DATA_W    = 32,
  parameter int unsigned         DEPTH     = 32,
  parameter int unsigned         ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        Address,
  output logic [DATA_W-1:0]        Instruction,
  output logic                     AddrFault,
  input  logic                     LoadStart,
  input  logic [$clog2(DEPTH):0]   LoadCount,
  input  logic                     LoadValid,
  input  logic [DATA_W-1:0]        LoadData,
  output logic                     LoadReady,
  output logic                     Loading,
  output logic                     LoadDone
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * BYTES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              ready_q, ready_d;
  logic              loading_q;
  logic              done_q, done_d;
  logic              we;
  logic [CNT_W-1:0]  eff_cnt;

  // Fetch-side address decode
  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic              below, beyond, misal;

  assign off    = Address - BASE_ADDR;
  assign below  = Address < BASE_ADDR;
  assign beyond = {1'b0, off} >= SPAN;
  assign misal  = (off & ADDR_W'(BYTES - 1)) != '0;
  assign idx    = off[OFF_W +: IDX_W];

  assign AddrFault   = below | beyond | misal;
  assign Instruction = (done_q && !AddrFault) ? mem[idx] : '0;

  assign LoadReady = ready_q;
  assign Loading   = loading_q;
  assign LoadDone  = done_q;

  // Zero or oversize counts mean a full-depth load
  assign eff_cnt = (LoadCount == '0 || LoadCount > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : LoadCount;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    we      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (LoadStart) begin
          state_d = FILL;
          ptr_d   = '0;
          rem_d   = eff_cnt;
        end
      end
      FILL: begin
        if (LoadValid && ready_q) begin
          we    = 1'b1;
          ptr_d = ptr_q + IDX_W'(1);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == FILL);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      ready_q   <= 1'b0;
      loading_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      ready_q   <= ready_d;
      loading_q <= ready_d;
      done_q    <= done_d;
    end
  end

  // Array is never cleared; reset only suppresses a same-edge write
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      mem[ptr_q] <= LoadData;
    end
  end

endmodule

// File: tb/tb_inst_mem_stream.sv
// Randomized bench for inst_mem_stream with a behavioural load/fetch model and
// per-cycle output comparison, plus literal spot checks.
module tb_inst_mem_stream;

  localparam int unsigned DW   = 32;
  localparam int unsigned DEP  = 32;
  localparam int unsigned AW   = 32;
  localparam logic [31:0] BASE = 32'h400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        AddrFault;
  logic        LoadStart;
  logic [5:0]  LoadCount;
  logic        LoadValid;
  logic [31:0] LoadData;
  logic        LoadReady;
  logic        Loading;
  logic        LoadDone;

  inst_mem_stream #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .Address(Address), .Instruction(Instruction),
    .AddrFault(AddrFault), .LoadStart(LoadStart), .LoadCount(LoadCount),
    .LoadValid(LoadValid), .LoadData(LoadData), .LoadReady(LoadReady),
    .Loading(Loading), .LoadDone(LoadDone)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int ready_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 filling, 2 loaded
  logic [31:0] m_mem [DEP];
  int m_mode = 0;
  int m_ptr  = 0;
  int m_left = 0;

  function automatic bit m_fault(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off < 0) || (off >= longint'(DEP * 4)) || (off % 4 != 0);
  endfunction

  function automatic logic [31:0] m_instr(input logic [31:0] a);
    if (m_mode != 2 || m_fault(a)) return 32'h0;
    return m_mem[(longint'(a) - longint'(BASE)) / 4];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_ptr = 0; m_left = 0;
    end else if (m_mode == 1) begin
      if (LoadValid) begin
        m_mem[m_ptr] = LoadData;
        m_ptr  = (m_ptr + 1) % DEP;
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 2;
      end
    end else if (LoadStart) begin
      m_mode = 1;
      m_ptr  = 0;
      m_left = (LoadCount == 0 || int'(LoadCount) > DEP) ? DEP : int'(LoadCount);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ready",   32'(LoadReady),   32'(m_mode == 1));
      chk("cyc_loading", 32'(Loading),     32'(m_mode == 1));
      chk("cyc_done",    32'(LoadDone),    32'(m_mode == 2));
      chk("cyc_fault",   32'(AddrFault),   32'(m_fault(Address)));
      chk("cyc_instr",   Instruction,      m_instr(Address));
      if (LoadReady) ready_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input int cnt);
    LoadStart = 1'b1;
    LoadCount = 6'(cnt);
    tick();
    LoadStart = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    return BASE - 32'd16 + 32'($urandom_range(0, DEP * 4 + 32));
  endfunction

  task automatic read_word(input string nm, input int i, input logic [31:0] exp);
    Address = BASE + 32'(4 * i);
    #1;
    chk(nm, Instruction, exp);
    tick();
  endtask

  logic [31:0] acc_q [$];
  bit [4:0]    vpat = 5'b10101;
  int          acc;
  int          n;
  int          d;

  initial begin
    rst_n = 1'b0; Address = BASE; LoadStart = 1'b0; LoadCount = '0;
    LoadValid = 1'b0; LoadData = '0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_ready", 32'(LoadReady), 32'h0);
    chk("rst_loading", 32'(Loading), 32'h0);
    chk("rst_done", 32'(LoadDone), 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    rst_n = 1'b1;
    tick();

    // Full load, count 0 means 32 words
    ready_cnt = 0;
    start(0);
    chk("fill_ready_on", 32'(LoadReady), 32'h1);
    for (int i = 0; i < 32; i++) begin
      LoadValid = 1'b1;
      LoadData  = 32'h1000_0000 + 32'(i);
      Address   = rand_addr();
      if (i == 31) chk("done_before_last", 32'(LoadDone), 32'h0);
      tick();
    end
    LoadValid = 1'b0;
    chk("done_after_last", 32'(LoadDone), 32'h1);
    chk("ready_after_last", 32'(LoadReady), 32'h0);
    tick(); tick();
    chk("ready_cycles", 32'(ready_cnt), 32'd32);
    for (int i = 0; i < 32; i++) read_word("full_read", i, 32'h1000_0000 + 32'(i));

    // Partial load with gaps; LoadStart mid-fill must be ignored
    start(3);
    d = 0;
    for (int k = 0; k < 5; k++) begin
      LoadValid = vpat[k];
      if (vpat[k]) begin
        LoadData = 32'hA + 32'(d);
        d++;
      end
      LoadStart = (k == 1);
      LoadCount = 6'd0;
      if (k == 4) chk("partial_done_early", 32'(LoadDone), 32'h0);
      tick();
      LoadStart = 1'b0;
    end
    LoadValid = 1'b0;
    chk("partial_done", 32'(LoadDone), 32'h1);
    read_word("partial_w0", 0, 32'hA);
    read_word("partial_w1", 1, 32'hB);
    read_word("partial_w2", 2, 32'hC);
    read_word("partial_w3", 3, 32'h1000_0003);

    // Address faults
    Address = 32'h3FC; #1; chk("fault_below", 32'(AddrFault), 32'h1); chk("fault_below_i", Instruction, 32'h0); tick();
    Address = 32'h480; #1; chk("fault_above", 32'(AddrFault), 32'h1); chk("fault_above_i", Instruction, 32'h0); tick();
    Address = 32'h402; #1; chk("fault_misal", 32'(AddrFault), 32'h1); chk("fault_misal_i", Instruction, 32'h0); tick();
    Address = 32'h47C; #1; chk("last_ok", 32'(AddrFault), 32'h0); chk("last_word", Instruction, 32'h1000_001F); tick();

    // LoadValid while loaded is dropped
    LoadValid = 1'b1; LoadData = 32'hDEAD_BEEF;
    tick();
    LoadValid = 1'b0;
    chk("drop_done", 32'(LoadDone), 32'h1);
    read_word("drop_w0", 0, 32'hA);

    // Oversize count clamps to 32, random valid gaps and data
    start(40);
    acc = 0; n = 0;
    acc_q.delete();
    while (m_mode == 1 && n < 400) begin
      LoadValid = 1'($urandom % 2);
      LoadData  = $urandom;
      Address   = rand_addr();
      if (LoadValid) begin
        acc++;
        acc_q.push_back(LoadData);
      end
      tick();
      n++;
    end
    LoadValid = 1'b0;
    if (n >= 400) chk("clamp_timeout", 32'(n), 32'd0);
    chk("clamp_accepts", 32'(acc), 32'd32);
    chk("clamp_done", 32'(LoadDone), 32'h1);

    // Reset on the same edge as the 5th accept
    start(0);
    for (int i = 0; i < 4; i++) begin
      LoadValid = 1'b1;
      LoadData  = 32'h5500_0000 + 32'(i);
      tick();
    end
    LoadData = 32'hBEEF_BEEF;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    LoadValid = 1'b0;
    chk("midrst_done", 32'(LoadDone), 32'h0);
    chk("midrst_ready", 32'(LoadReady), 32'h0);
    Address = BASE + 32'd16; #1;
    chk("midrst_instr", Instruction, 32'h0);
    tick();

    // Short reload exposes words 3 and 4 left by the aborted load
    start(3);
    for (int i = 0; i < 3; i++) begin
      LoadValid = 1'b1;
      LoadData  = 32'h77 + 32'(i);
      tick();
    end
    LoadValid = 1'b0;
    read_word("after_rst_w3", 3, 32'h5500_0003);
    if (acc_q.size() > 4) read_word("after_rst_w4", 4, acc_q[4]);

    // New full load completes normally
    start(0);
    for (int i = 0; i < 32; i++) begin
      LoadValid = 1'b1;
      LoadData  = $urandom;
      Address   = rand_addr();
      tick();
    end
    LoadValid = 1'b0;
    chk("reload_done", 32'(LoadDone), 32'h1);
    for (int i = 0; i < 40; i++) begin
      Address = rand_addr();
      tick();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_stream.md
# inst_mem_stream

Parametrised instruction memory for the MIPS pipeline fetch stage. It replaces the one-shot, full-width parallel load with a streamed word-by-word loader that uses a valid/ready handshake and a programmable word count. Fetch reads stay combinational, so the IF stage sees the instruction in the same cycle as the address. Fetch is gated to NOP while a load is in progress or after an address fault.

## Interface
- DATA_W, 32: instruction width in bits.
- DEPTH, 32: number of words; power of two, at least 2.
- ADDR_W, 32: byte-address width.
- BASE_ADDR, 0: byte address of word 0; must be DATA_W/8-aligned.

- clk  in  1: single clock; all state updates on rising edge.
- rst_n  in  1: synchronous, active-low reset.
- Address  in  ADDR_W: fetch byte address (PC).
- Instruction  out  DATA_W: fetched word; 0 (NOP) when gated.
- AddrFault  out  1: combinational; Address is out of range or misaligned.
- LoadStart  in  1: pulse that begins a load; sampled only in IDLE or DONE.
- LoadCount  in  $clog2(DEPTH)+1: words to load; sampled with LoadStart.
- LoadValid  in  1: LoadData is valid.
- LoadData  in  DATA_W: next word to write.
- LoadReady  out  1: registered; high only in FILL.
- Loading  out  1: registered; high in FILL.
- LoadDone  out  1: registered; high in DONE.

## Operation
- Memory array: DEPTH×DATA_W. It has no reset and no clearing; contents persist across reset and across loads except for words that are rewritten.
- Byte offset: off = Address − BASE_ADDR.
- Word index: off >> log2(DATA_W/8), low $clog2(DEPTH) bits.
- AddrFault = (Address < BASE_ADDR) | (off ≥ DEPTH·DATA_W/8) | (off % (DATA_W/8) ≠ 0).
- Instruction = mem[index] only when state = DONE and AddrFault = 0; otherwise 0.
- FSM states: IDLE, FILL, DONE.
  - IDLE → FILL on LoadStart.
  - FILL → DONE when the last word is accepted.
  - DONE → FILL on LoadStart.
  - LoadStart is ignored while in FILL.
- On entry to FILL: ptr ← 0 and remaining ← effective count.
  - Effective count = DEPTH if LoadCount = 0 or LoadCount > DEPTH; otherwise LoadCount.
- Accept occurs when LoadValid & LoadReady at a rising edge:
  - mem[ptr] ← LoadData;
  - ptr ← ptr + 1, with wrap-around modulo DEPTH (it cannot exceed DEPTH−1 under the count clamp);
  - remaining ← remaining − 1.
- Accepting with remaining = 1 moves the FSM to DONE on the same edge.
- LoadValid without LoadReady (IDLE or DONE) is dropped, and no write occurs.
- Words at index ≥ effective count keep their old contents.
- Reset (rst_n = 0 at an edge): state ← IDLE, ptr ← 0, remaining ← 0, LoadReady/Loading/LoadDone ← 0.
  - Reset has priority over any same-edge accept or LoadStart.
  - If reset arrives mid-load, words already written stay written, but fetch is gated until a new load completes.

## Timing
- Reset values: LoadReady = 0, Loading = 0, LoadDone = 0, Instruction = 0.
- AddrFault is combinational and depends only on Address.
- LoadStart is sampled at edge N; LoadReady = Loading = 1 from cycle N+1.
- Accepts happen at most one per cycle, back to back with no bubble. K words take K accepting edges.
- Last accept at edge M: LoadDone = 1 and LoadReady = 0 in cycle M+1, and Instruction is valid in cycle M+1 (read-after-load latency is 1 cycle from the final write).
- Read latency: 0 cycles; Instruction follows Address combinationally.
- Reload from DONE: LoadDone falls and Instruction is gated to 0 starting in the cycle after LoadStart is sampled.

## Test plan
- Reset then full load:
  - Stimulus: rst_n low for 2 cycles; LoadStart with LoadCount = 0; stream 32 words of 0x1000_0000+i with LoadValid held high.
  - Required: LoadReady is high for exactly 32 cycles and LoadDone rises 1 cycle after the 32nd accept.
  - Then Address = 4·i returns 0x1000_0000+i for all i, and Instruction = 0 during FILL.
- Partial load with gaps:
  - Stimulus: after the full load, LoadStart with LoadCount = 3; LoadValid toggles 1,0,1,0,1 with data 0xA, 0xB, 0xC.
  - Required: words 0–2 = 0xA/0xB/0xC, word 3 still 0x1000_0003, and LoadDone rises after the third accept.
- Faults:
  - With BASE_ADDR = 0x400, DEPTH = 32: Address = 0x3FC, 0x480, and 0x402 → AddrFault = 1 and Instruction = 0.
  - Address = 0x47C → AddrFault = 0 and the last word is returned.
- Ignored control:
  - LoadStart pulsed mid-FILL: no restart and no ptr reset.
  - LoadValid pulsed in DONE: memory unchanged.
  - LoadCount = 40 (DEPTH = 32): clamped to 32 words.
- Reset mid-load:
  - Stimulus: assert rst_n = 0 on the same edge as the 5th accept.
  - Required: the 5th word is not written; state = IDLE and LoadDone = 0, with Instruction = 0.
  - A new 32-word load then completes normally.
